// File: rtl/axi_ddr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_ddr_pkg
// Description : Shared AXI4 read constants and the read-master state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_ddr_pkg;

   localparam logic [1:0] BURST_INCR      = 2'b01;
   localparam logic [1:0] RESP_OKAY       = 2'b00;
   localparam logic [3:0] ARCACHE_DEFAULT = 4'b0010;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_AR     = 2'd1,
      ST_R_WAIT = 2'd2,
      ST_SER    = 2'd3
   } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_rd_beat_serializer.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_beat_serializer
// Description : Loads one R beat and emits its bytes LSB first, one per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_beat_serializer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  rd_clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] beat_data,
   output logic [7:0]            byte_out,
   output logic                  byte_valid,
   output logic                  last_byte
);

   localparam int c_nbytes = DATA_WIDTH / 8;
   localparam int c_idx_w  = (c_nbytes > 1) ? $clog2(c_nbytes) : 1;
   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nbytes - 1);

   logic [DATA_WIDTH-1:0] r_shift;
   logic [c_idx_w-1:0]    r_idx;
   logic [7:0]            r_byte;
   logic                  r_valid;

   // byte_out keeps its last value once the beat is exhausted
   always_ff @(posedge rd_clk) begin
      if (!rst_n) begin
         r_shift <= '0;
         r_idx   <= '0;
         r_byte  <= '0;
         r_valid <= 1'b0;
      end else if (load) begin
         r_byte  <= beat_data[7:0];
         r_shift <= beat_data >> 8;
         r_idx   <= '0;
         r_valid <= 1'b1;
      end else if (r_valid) begin
         if (r_idx == c_last_idx) begin
            r_valid <= 1'b0;
         end else begin
            r_byte  <= r_shift[7:0];
            r_shift <= r_shift >> 8;
            r_idx   <= r_idx + 1'b1;
         end
      end
   end

   assign byte_out   = r_byte;
   assign byte_valid = r_valid;
   assign last_byte  = r_valid && (r_idx == c_last_idx);

endmodule
`default_nettype wire

// File: rtl/axi_ddr_rd_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_ddr_rd_master
// Description : AXI4 burst read master streaming an address range out as bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_ddr_rd_master
   import axi_ddr_pkg::*;
#(
   parameter int C_M_AXI_ID_WIDTH   = 1,
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int BURST_LEN          = 16
) (
   input  logic                          rd_clk,
   input  logic                          rst_n,
   input  logic                          rd_begin,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] rd_addr_begin,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] rd_addr_end,
   output logic                          rd_data_busy,
   output logic [7:0]                    rd_data_out,
   output logic                          rd_valid_out,
   output logic                          rd_err,
   output logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_arid,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]                    m_axi_arlen,
   output logic [2:0]                    m_axi_arsize,
   output logic [1:0]                    m_axi_arburst,
   output logic                          m_axi_arlock,
   output logic [3:0]                    m_axi_arcache,
   output logic [2:0]                    m_axi_arprot,
   output logic [3:0]                    m_axi_arqos,
   output logic                          m_axi_arvalid,
   input  logic                          m_axi_arready,
   input  logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_rid,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]                    m_axi_rresp,
   input  logic                          m_axi_rlast,
   input  logic                          m_axi_rvalid,
   output logic                          m_axi_rready
);

   localparam logic [C_M_AXI_ADDR_WIDTH:0] c_step =
      (C_M_AXI_ADDR_WIDTH+1)'(BURST_LEN * (C_M_AXI_DATA_WIDTH / 8));

   rd_state_t                     r_state, w_state_nxt;
   logic [C_M_AXI_ADDR_WIDTH-1:0] r_araddr;
   logic [C_M_AXI_ADDR_WIDTH-1:0] r_end;
   logic                          r_err;
   logic                          r_rlast;
   logic [C_M_AXI_ADDR_WIDTH:0]   w_next_addr;
   logic                          w_more;
   logic                          w_beat_acc;
   logic                          w_ser_last;
   logic                          w_unused;

   assign m_axi_arid    = '0;
   assign m_axi_arlen   = 8'(BURST_LEN - 1);
   assign m_axi_arsize  = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
   assign m_axi_arburst = BURST_INCR;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = ARCACHE_DEFAULT;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arqos   = 4'b0000;
   assign m_axi_araddr  = r_araddr;
   assign rd_err        = r_err;

   assign w_unused = ^{m_axi_rid, m_axi_rresp ^ RESP_OKAY};

   // Extra bit catches wrap-around past the top of the address space
   assign w_next_addr = {1'b0, r_araddr} + c_step;
   assign w_more      = !w_next_addr[C_M_AXI_ADDR_WIDTH] &&
                        (w_next_addr[C_M_AXI_ADDR_WIDTH-1:0] <= r_end);
   assign w_beat_acc  = (r_state == ST_R_WAIT) && m_axi_rvalid;

   always_ff @(posedge rd_clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      rd_data_busy  = 1'b1;
      case (r_state)
         ST_IDLE: begin
            rd_data_busy = 1'b0;
            if (rd_begin) w_state_nxt = ST_AR;
         end
         ST_AR: begin
            m_axi_arvalid = 1'b1;
            if (m_axi_arready) w_state_nxt = ST_R_WAIT;
         end
         ST_R_WAIT: begin
            m_axi_rready = 1'b1;
            if (m_axi_rvalid) w_state_nxt = ST_SER;
         end
         ST_SER: begin
            if (w_ser_last) begin
               if (!r_rlast)    w_state_nxt = ST_R_WAIT;
               else if (w_more) w_state_nxt = ST_AR;
               else             w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge rd_clk) begin
      if (!rst_n) begin
         r_araddr <= '0;
         r_end    <= '0;
         r_err    <= 1'b0;
         r_rlast  <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) && rd_begin) begin
            r_araddr <= rd_addr_begin;
            r_end    <= rd_addr_end;
            r_err    <= 1'b0;
         end
         if (w_beat_acc) begin
            r_rlast <= m_axi_rlast;
            if (m_axi_rresp[1]) r_err <= 1'b1;
         end
         if ((r_state == ST_SER) && w_ser_last && r_rlast && w_more)
            r_araddr <= w_next_addr[C_M_AXI_ADDR_WIDTH-1:0];
      end
   end

   axi_rd_beat_serializer #(
      .DATA_WIDTH (C_M_AXI_DATA_WIDTH)
   ) u_ser (
      .rd_clk     (rd_clk),
      .rst_n      (rst_n),
      .load       (w_beat_acc),
      .beat_data  (m_axi_rdata),
      .byte_out   (rd_data_out),
      .byte_valid (rd_valid_out),
      .last_byte  (w_ser_last)
   );

endmodule
`default_nettype wire

// File: tb/tb_axi_ddr_rd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_ddr_rd_master
// Description : Scoreboard bench with an AXI read-slave model for axi_ddr_rd_master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_ddr_rd_master;

   localparam int BL     = 16;
   localparam int BUDGET = 3000;

   logic        rd_clk;
   logic        rst_n;
   logic        rd_begin;
   logic [31:0] rd_addr_begin, rd_addr_end;
   logic        rd_data_busy, rd_valid_out, rd_err;
   logic [7:0]  rd_data_out;
   logic [0:0]  m_axi_arid, m_axi_rid;
   logic [31:0] m_axi_araddr, m_axi_rdata;
   logic [7:0]  m_axi_arlen;
   logic [2:0]  m_axi_arsize, m_axi_arprot;
   logic [1:0]  m_axi_arburst, m_axi_rresp;
   logic        m_axi_arlock;
   logic [3:0]  m_axi_arcache, m_axi_arqos;
   logic        m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;

   axi_ddr_rd_master dut (
      .rd_clk(rd_clk), .rst_n(rst_n), .rd_begin(rd_begin),
      .rd_addr_begin(rd_addr_begin), .rd_addr_end(rd_addr_end),
      .rd_data_busy(rd_data_busy), .rd_data_out(rd_data_out),
      .rd_valid_out(rd_valid_out), .rd_err(rd_err),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
      .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   int n_checks = 0;
   int n_errs   = 0;
   int cyc      = 0;

   logic [8:0]  exp_q[$];
   logic [31:0] ar_q[$];

   // slave model state
   int          ar_stall = 0;
   int          stall_cnt = 0;
   bit          err_on = 0;
   bit          err_armed = 0;
   bit          bur_active = 0;
   int          bur_beat = 0;
   int          n_ar = 0;
   int          n_bytes = 0;
   int          last_byte_cyc = 0;
   logic [31:0] held_addr = '0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   initial begin
      rd_clk = 1'b0;
      forever #5 rd_clk = ~rd_clk;
   end

   always @(posedge rd_clk) cyc <= cyc + 1;

   // Slave + byte monitor; everything sampled and driven on the falling edge
   initial begin
      logic [31:0] d;
      logic [8:0]  eb;
      logic [31:0] ea;
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b0;
      m_axi_rdata   = '0;
      m_axi_rresp   = 2'b00;
      m_axi_rlast   = 1'b0;
      m_axi_rid     = '0;
      forever begin
         @(negedge rd_clk);
         if (err_armed) check("rd_err_sticky", rd_err, 1);
         if (rd_valid_out) begin
            eb = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
            check("byte", {1'b0, rd_data_out}, eb);
            n_bytes++;
            last_byte_cyc = cyc;
         end
         if (m_axi_rready && bur_active) begin
            d = $urandom;
            m_axi_rdata  = d;
            m_axi_rvalid = 1'b1;
            m_axi_rlast  = (bur_beat == BL - 1);
            m_axi_rresp  = (err_on && n_ar == 1 && bur_beat == 3) ? 2'b10 : 2'b00;
            if (m_axi_rresp[1]) begin
               check("rd_err_before_bad_beat", rd_err, 0);
               err_armed = 1;
            end
            for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, d[8*i +: 8]});
            bur_beat++;
            if (bur_beat == BL) bur_active = 0;
         end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
            m_axi_rresp  = 2'b00;
         end
         if (m_axi_arvalid) begin
            if (stall_cnt == 0) held_addr = m_axi_araddr;
            else begin
               check("ar_stall_addr", m_axi_araddr, held_addr);
               check("ar_stall_rready", m_axi_rready, 0);
            end
            if (stall_cnt < ar_stall) begin
               m_axi_arready = 1'b0;
               stall_cnt++;
            end else begin
               m_axi_arready = 1'b1;
               stall_cnt = 0;
               ea = (ar_q.size() != 0) ? ar_q.pop_front() : 32'hDEAD_BEEF;
               check("araddr", m_axi_araddr, ea);
               n_ar++;
               bur_active = 1;
               bur_beat = 0;
            end
         end else begin
            if (stall_cnt != 0) check("ar_valid_dropped", m_axi_arvalid, 1);
            m_axi_arready = 1'b0;
            stall_cnt = 0;
         end
      end
   end

   task automatic run(input logic [31:0] b, input logic [31:0] e, input int stall,
                      input bit err, input bit mid, input int exp_bursts);
      logic [32:0] nx;
      logic [31:0] a;
      int          n;
      int          fall_cyc;
      ar_q.delete();
      n_ar = 0; n_bytes = 0; ar_stall = stall; err_on = err; err_armed = 0;
      a = b;
      ar_q.push_back(a);
      while (1) begin
         nx = {1'b0, a} + 33'd64;
         if (nx[32] || nx[31:0] > e) break;
         a = nx[31:0];
         ar_q.push_back(a);
      end
      @(negedge rd_clk);
      rd_addr_begin = b; rd_addr_end = e; rd_begin = 1'b1;
      @(negedge rd_clk);
      rd_begin = 1'b0;
      check("busy_rise", rd_data_busy, 1);
      check("arvalid_rise", m_axi_arvalid, 1);
      check("rd_err_cleared", rd_err, 0);
      n = 0;
      while (rd_data_busy && n < BUDGET) begin
         @(negedge rd_clk);
         n++;
         if (mid && n == 40) begin
            rd_addr_begin = 32'h9000; rd_addr_end = 32'h5000_0000; rd_begin = 1'b1;
         end else begin
            rd_begin = 1'b0;
         end
      end
      fall_cyc = cyc;
      check("done_in_budget", n < BUDGET, 1);
      check("ar_count", n_ar, exp_bursts);
      check("byte_count", n_bytes, exp_bursts * BL * 4);
      check("busy_fall_latency", fall_cyc - last_byte_cyc, 1);
      check("exp_bytes_left", exp_q.size(), 0);
      check("exp_ar_left", ar_q.size(), 0);
      if (err) check("rd_err_at_end", rd_err, 1);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; rd_begin = 1'b0; rd_addr_begin = '0; rd_addr_end = '0;
      repeat (3) @(negedge rd_clk);
      check("rst_busy", rd_data_busy, 0);
      check("rst_arvalid", m_axi_arvalid, 0);
      check("rst_rready", m_axi_rready, 0);
      check("rst_valid", rd_valid_out, 0);
      check("rst_err", rd_err, 0);
      check("rst_data", rd_data_out, 0);
      check("rst_araddr", m_axi_araddr, 0);
      check("arlen", m_axi_arlen, 15);
      check("arsize", m_axi_arsize, 2);
      check("arburst", m_axi_arburst, 1);
      check("arcache", m_axi_arcache, 4'b0010);
      check("ar_misc", {m_axi_arid, m_axi_arlock, m_axi_arprot, m_axi_arqos}, 0);
      rst_n = 1'b1;

      run(32'h0100_0000, 32'h0100_01C0, 0, 0, 0, 8);
      run(32'h0000_2000, 32'h0000_2040, 5, 0, 0, 2);
      run(32'h0000_0100, 32'h0000_0000, 0, 0, 0, 1);
      run(32'h0000_1000, 32'h0000_1040, 0, 1, 0, 2);
      run(32'h0000_4000, 32'h0000_40C0, 0, 0, 1, 4);
      run(32'hFFFF_FFC0, 32'hFFFF_FFFF, 0, 0, 0, 1);

      // reset in the middle of byte serialization
      ar_q.delete(); ar_q.push_back(32'h8000);
      ar_stall = 0; err_on = 0; err_armed = 0;
      @(negedge rd_clk);
      rd_addr_begin = 32'h8000; rd_addr_end = 32'h8000; rd_begin = 1'b1;
      @(negedge rd_clk);
      rd_begin = 1'b0;
      n = 0;
      while (!rd_valid_out && n < 200) begin
         @(negedge rd_clk);
         n++;
      end
      check("ser_reached", rd_valid_out, 1);
      rst_n = 1'b0;
      @(posedge rd_clk);
      #2;
      exp_q.delete(); ar_q.delete();
      bur_active = 0; stall_cnt = 0;
      @(negedge rd_clk);
      check("mid_rst_busy", rd_data_busy, 0);
      check("mid_rst_arvalid", m_axi_arvalid, 0);
      check("mid_rst_rready", m_axi_rready, 0);
      check("mid_rst_valid", rd_valid_out, 0);
      check("mid_rst_data", rd_data_out, 0);
      check("mid_rst_araddr", m_axi_araddr, 0);
      check("mid_rst_err", rd_err, 0);
      rst_n = 1'b1;
      run(32'h0000_0000, 32'h0000_0040, 0, 0, 0, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axi_ddr_rd_master.md
AXI_DDR_RD_MASTER -- requirements
Module: axi_ddr_rd_master

Interface
REQ-001 SHALL have parameter C_M_AXI_ID_WIDTH, default 1, AXI ID width.
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, R data width; legal values 32 and 64.
REQ-004 SHALL have parameter BURST_LEN, default 16, beats per burst; legal range 1..256.
REQ-005 SHALL have port rd_clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port rd_begin  in  1  single-cycle read request strobe.
REQ-008 SHALL have port rd_addr_begin  in  ADDR  start byte address of the first burst.
REQ-009 SHALL have port rd_addr_end  in  ADDR  inclusive upper bound for burst start addresses.
REQ-010 SHALL have port rd_data_busy  out  1  high while a transfer is in progress.
REQ-011 SHALL have port rd_data_out  out  8  serialized read byte.
REQ-012 SHALL have port rd_valid_out  out  1  qualifies rd_data_out for one cycle.
REQ-013 SHALL have port rd_err  out  1  sticky flag for an error response.
REQ-014 SHALL have ports m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos/arvalid  out  AXI4 widths  AR channel.
REQ-015 SHALL have port m_axi_arready  in  1  AR handshake.
REQ-016 SHALL have ports m_axi_rid/rdata/rresp/rlast/rvalid  in  AXI4 widths  R channel.
REQ-017 SHALL have port m_axi_rready  out  1  R handshake.

Function
REQ-018 SHALL drive the constant AR fields as follows: arid=0, arlen=BURST_LEN-1, arsize=log2(DATA/8), arburst=INCR(01), arlock=0, arcache=0010, arprot=000, arqos=0.
REQ-019 SHALL implement the FSM states IDLE, AR, R_WAIT and SER.
REQ-020 SHALL, in IDLE, latch rd_addr_begin and rd_addr_end and clear rd_err when rd_begin is sampled high in cycle N, then enter AR with rd_data_busy=1 and arvalid=1 at N+1.
REQ-021 SHALL ignore rd_begin while rd_data_busy=1, with no effect on the latched addresses.
REQ-022 SHALL hold arvalid and araddr stable in AR until arready=1, then enter R_WAIT with rready=1 in the next cycle.
REQ-023 SHALL, in R_WAIT, capture rdata and rlast on rvalid&&rready in cycle K, deassert rready at K+1, and enter SER.
REQ-024 SHALL, in SER, emit DATA/8 bytes in consecutive cycles starting at K+1, least-significant byte first, with rd_valid_out=1 on each byte; rready SHALL stay 0 throughout SER.
REQ-025 SHALL, in the cycle after the last byte, enter R_WAIT if the captured rlast=0; if rlast=1, it SHALL enter AR when another burst is due, otherwise IDLE with rd_data_busy=0.
REQ-026 SHALL issue the first burst at rd_addr_begin unconditionally, including when rd_addr_end < rd_addr_begin.
REQ-027 SHALL compute each following burst address as the previous address + BURST_LEN*DATA/8, and issue it only if the unsigned sum is <= the latched end and the addition did not overflow ADDR bits.
REQ-028 SHALL terminate a burst only on rlast and SHALL NOT count beats.
REQ-029 SHALL set rd_err when rresp[1]=1 on an accepted beat, keep it set until the next accepted rd_begin, and still forward that beat's data.
REQ-030 SHALL hold rd_data_out at its last value when rd_valid_out=0 and SHALL ignore rid.

Reset
REQ-031 SHALL, while rst_n=0 at a clock edge, force the FSM to IDLE and drive arvalid, rready, rd_data_busy, rd_valid_out, rd_err, rd_data_out and araddr to 0.
REQ-032 SHALL, on reset mid-transfer, abandon the outstanding burst and return to IDLE in the next cycle; downstream recovery is out of scope.

Structure
REQ-033 SHALL place the AXI constants (BURST_INCR, RESP_OKAY, ARCACHE_DEFAULT) and the FSM state encoding in the shared package axi_ddr_pkg.
REQ-034 SHALL contain one natural sub-module, axi_rd_beat_serializer, which takes one beat and emits bytes; the address/FSM logic SHALL stay in the top module.

Verification
REQ-035 SHALL cover: begin=0x0100_0000, end=0x0100_01C0, DATA=32, BURST_LEN=16, zero-wait slave -> exactly 8 AR handshakes at +0x40 steps, 512 bytes out in LSB-first order, busy falls 1 cycle after the last byte.
REQ-036 SHALL cover: arready held low for 5 cycles -> arvalid and araddr stable for all 6 cycles, and no rready during that time.
REQ-037 SHALL cover: end < begin (begin=0x100, end=0x0) -> a single burst, 64 bytes, then IDLE.
REQ-038 SHALL cover: rresp=10 on beat 3 of burst 0 -> rd_err=1 from that beat on, all data still delivered, rd_err cleared by the next rd_begin.
REQ-039 SHALL cover: rd_begin pulsed mid-transfer -> no new AR, and the latched end is unchanged.
REQ-040 SHALL cover: rst_n low for 1 cycle during SER -> all outputs 0 next cycle, FSM in IDLE, and a fresh rd_begin completes normally.
